// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand sequencer.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GOT_A = 2'd1,
        GOT_B = 2'd2,
        ISSUE = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_SADD = 3'd2;
    localparam logic [2:0] OP_SSUB = 3'd3;
    localparam logic [2:0] OP_CMP  = 3'd4;
    localparam logic [2:0] OP_SCMP = 3'd5;

    localparam int unsigned OP_MAX = 5;

    // Op codes travel on sw[2:0]; sw[3] set is always illegal.
    function automatic logic op_legal(input logic [3:0] code, input int unsigned max_code);
        return !code[3] && (32'(code[2:0]) <= max_code);
    endfunction

endpackage

// File: rtl/calc_btn_cond.sv
// Button conditioner: 2-FF synchronizer plus rising-edge press detect.
// With CALC_DEBOUNCE_EN defined, a press also needs DB_CYCLES stable-high cycles.
module calc_btn_cond #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign level = sync2;

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          fired;

    // Counter saturates at DB_CYCLES; fired limits output to one press per hold.
    always_ff @(posedge clk) begin
        if (!rst_n || !sync2) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else begin
            if (cnt != CW'(DB_CYCLES)) cnt <= cnt + 1'b1;
            if (cnt == CW'(DB_CYCLES)) fired <= 1'b1;
        end
    end

    assign press = sync2 && (cnt == CW'(DB_CYCLES)) && !fired;
`else
    localparam int unsigned DB_UNUSED = DB_CYCLES;

    logic prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sync2;
    end

    assign press = sync2 & ~prev;
`endif

endmodule

// File: rtl/calc_operand_seq.sv
// Operand sequencer: captures A, B and op code from sw on Enter presses and
// issues them as one valid/ready request. Optional debounce: CALC_DEBOUNCE_EN.
module calc_operand_seq
    import calc_pkg::state_t, calc_pkg::IDLE, calc_pkg::GOT_A,
           calc_pkg::GOT_B, calc_pkg::ISSUE, calc_pkg::op_legal;
#(
    parameter int unsigned OP_MAX    = calc_pkg::OP_MAX,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic [2:0] s_out,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       op_err,
    output logic [1:0] state_o,
    output logic [7:0] issue_cnt
);

    state_t     state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [2:0] s_reg;
    logic       enter_level_unused;
    logic       enter_press;
    logic       clr_level;
    logic       clr_press_unused;

    calc_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_enter),
        .level (enter_level_unused),
        .press (enter_press)
    );

    calc_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .level (clr_level),
        .press (clr_press_unused)
    );

    // Clear is level-driven and overrides everything except the transaction count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            op_valid  <= 1'b0;
            op_err    <= 1'b0;
            issue_cnt <= '0;
        end else if (clr_level) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            op_valid <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            op_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enter_press) begin
                        a_reg <= sw;
                        state <= GOT_A;
                    end
                end
                GOT_A: begin
                    if (enter_press) begin
                        b_reg <= sw;
                        state <= GOT_B;
                    end
                end
                GOT_B: begin
                    if (enter_press) begin
                        if (op_legal(sw, OP_MAX)) begin
                            s_reg    <= sw[2:0];
                            op_valid <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        state     <= IDLE;
                        issue_cnt <= issue_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_out   = a_reg;
    assign b_out   = b_reg;
    assign s_out   = s_reg;
    assign state_o = state;

endmodule

// File: tb/tb_calc_operand_seq.sv
// Self-checking bench for calc_operand_seq: vector table, corner sequences,
// and randomized operations checked against a transaction-level model.
module tb_calc_operand_seq;

`ifdef CALC_DEBOUNCE_EN
    localparam int LAT  = 6;
    localparam int HOLD = 7;
`else
    localparam int LAT  = 2;
    localparam int HOLD = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic       op_ready = 1'b0;
    logic [3:0] a_out;
    logic [3:0] b_out;
    logic [2:0] s_out;
    logic       op_valid;
    logic       op_err;
    logic [1:0] state_o;
    logic [7:0] issue_cnt;

    int tests = 0;
    int fails = 0;
    int err_cycles = 0;
    int edge_n = 0;

    calc_operand_seq #(.OP_MAX(5), .DB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .a_out     (a_out),
        .b_out     (b_out),
        .s_out     (s_out),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_err    (op_err),
        .state_o   (state_o),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;
    always @(negedge clk) if (op_err === 1'b1) err_cycles++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Transaction-level reference model
    int         m_st;
    logic [3:0] m_a, m_b;
    logic [2:0] m_s;
    int         m_cnt;

    function automatic int model_enter(input logic [3:0] v);
        int e = 0;
        case (m_st)
            0: begin m_a = v; m_st = 1; end
            1: begin m_b = v; m_st = 2; end
            2: begin
                if (v < 8 && v <= 5) begin m_s = v[2:0]; m_st = 3; end
                else e = 1;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_clear();
        m_st = 0; m_a = 0; m_b = 0; m_s = 0;
    endtask

    task automatic model_ready();
        if (m_st == 3) begin m_st = 0; m_cnt = (m_cnt + 1) % 256; end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic do_enter(input logic [3:0] v);
        @(negedge clk);
        sw = v;
        btn_enter = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_enter = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        btn_clear = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_clear = 1'b0;
        repeat (LAT + 3) @(negedge clk);
    endtask

    task automatic do_ready();
        @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input int st, input int v,
                           input int a, input int b, input int s);
        chk({tag, " state"}, state_o, st);
        chk({tag, " valid"}, op_valid, v);
        chk({tag, " a"}, a_out, a);
        chk({tag, " b"}, b_out, b);
        chk({tag, " s"}, s_out, s);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_st, (m_st == 3) ? 1 : 0, m_a, m_b, m_s);
        chk({tag, " cnt"}, issue_cnt, m_cnt);
    endtask

    typedef struct {
        int         act;   // 0 enter, 1 ready pulse, 2 clear
        logic [3:0] val;
        int         st, v, a, b, s, err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int k, e0, act, e, exp_err;
        logic [3:0] r;

        vecs[0]  = '{0, 4'd3, 1, 0, 3, 0, 0, 0};
        vecs[1]  = '{0, 4'd9, 2, 0, 3, 9, 0, 0};
        vecs[2]  = '{0, 4'd1, 3, 1, 3, 9, 1, 0};
        vecs[3]  = '{1, 4'd0, 0, 0, 3, 9, 1, 0};
        vecs[4]  = '{1, 4'd0, 0, 0, 3, 9, 1, 0};  // ready outside ISSUE ignored
        vecs[5]  = '{0, 4'd7, 1, 0, 7, 9, 1, 0};
        vecs[6]  = '{0, 4'd2, 2, 0, 7, 2, 1, 0};
        vecs[7]  = '{0, 4'd6, 2, 0, 7, 2, 1, 1};
        vecs[8]  = '{0, 4'd13, 2, 0, 7, 2, 1, 1}; // sw[3] set
        vecs[9]  = '{0, 4'd5, 3, 1, 7, 2, 5, 0};
        vecs[10] = '{0, 4'd8, 3, 1, 7, 2, 5, 0};  // enter in ISSUE ignored
        vecs[11] = '{1, 4'd0, 0, 0, 7, 2, 5, 0};
        vecs[12] = '{0, 4'd4, 1, 0, 4, 2, 5, 0};
        vecs[13] = '{2, 4'd0, 0, 0, 0, 0, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset cnt", issue_cnt, 0);
        chk("reset err", op_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Press latency: capture lands exactly LAT edges after first sample
        @(negedge clk);
        sw = 4'd3;
        btn_enter = 1'b1;
        k = edge_n + 1;
        repeat (HOLD) @(negedge clk);
        btn_enter = 1'b0;
        while (edge_n < k + LAT - 1) @(negedge clk);
        chk("latency before", state_o, 0);
        @(negedge clk);
        chk("latency at", state_o, 1);
        chk("latency a", a_out, 3);
        repeat (LAT + 3) @(negedge clk);

        // Main sequence 3/9/1, held 20 cycles with op_ready low
        do_enter(4'd9);
        do_enter(4'd1);
        chk_all("seq", 3, 1, 3, 9, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", i), op_valid, 1);
            chk($sformatf("hold%0d abs", i), {a_out, b_out, s_out}, {4'd3, 4'd9, 3'd1});
        end
        do_ready();
        chk_all("accept", 0, 0, 3, 9, 1);
        chk("accept cnt", issue_cnt, 1);

        // Vector table
        do_reset();
        for (int i = 0; i < 14; i++) begin
            e0 = err_cycles;
            case (vecs[i].act)
                0: do_enter(vecs[i].val);
                1: do_ready();
                default: do_clear();
            endcase
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].s);
            chk($sformatf("vec%0d err cycles", i), err_cycles - e0, vecs[i].err);
        end
        chk("vec cnt", issue_cnt, 2);

        // Enter pressed 3 times in ISSUE
        do_enter(4'd2); do_enter(4'd4); do_enter(4'd3);
        for (int i = 0; i < 3; i++) do_enter(4'hF);
        chk_all("issue enters", 3, 1, 2, 4, 3);
        do_ready();

        // Clear and Enter together in GOT_A
        do_enter(4'd6);
        chk("gota pre", state_o, 1);
        @(negedge clk);
        sw = 4'd11;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (LAT + 6) @(negedge clk);
        chk_all("clr+enter", 0, 0, 0, 0, 0);
        chk("clr+enter cnt", issue_cnt, 3);

`ifdef CALC_DEBOUNCE_EN
        // Short glitch: no capture
        @(negedge clk);
        sw = 4'd7;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch state", state_o, 0);
        // Held 10 cycles: one capture at edge k+6
        btn_enter = 1'b1;
        k = edge_n + 1;
        while (edge_n < k + 5) @(negedge clk);
        chk("db before", state_o, 0);
        @(negedge clk);
        chk("db at", state_o, 1);
        while (edge_n < k + 9) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);
        chk("db once", state_o, 1);
        do_clear();
`endif

        // 256 transactions wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_enter(4'(i));
            do_enter(4'(i >> 4));
            do_enter(4'(i % 6));
            do_ready();
            if (i == 254) chk("cnt 255", issue_cnt, 255);
        end
        chk("cnt wrap", issue_cnt, 0);

        // Reset mid-ISSUE aborts without counting
        do_enter(4'd1); do_enter(4'd2); do_enter(4'd3);
        chk("pre abort valid", op_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        op_ready = 1'b1;
        @(negedge clk);
        chk_all("abort", 0, 0, 0, 0, 0);
        chk("abort cnt", issue_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        op_ready = 1'b0;
        chk("abort idle cnt", issue_cnt, 0);

        // Randomized operations against the model
        m_st = 0; m_a = 0; m_b = 0; m_s = 0; m_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            act = $urandom_range(0, 9);
            e0 = err_cycles;
            exp_err = 0;
            if (act < 6) begin
                r = 4'($urandom_range(0, 15));
                e = model_enter(r);
                exp_err = e;
                do_enter(r);
            end else if (act < 9) begin
                model_ready();
                do_ready();
            end else begin
                model_clear();
                do_clear();
            end
            chk_model($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d err", i), err_cycles - e0, exp_err);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/calc_operand_seq.md
Name: calc_operand_seq

Overview:
- Upstream operand sequencer for the 4-bit calculator stage.
- Collects operand A, operand B and the 3-bit op code one after another from a shared 4-bit switch bus, one Enter button press per field.
- Presents the three fields as a single valid/ready transaction to the calculator.
- Counts completed transactions.

Parameters:
- OP_MAX, 5: highest legal op code; larger codes are rejected.
- DB_CYCLES, 4: consecutive stable cycles required for a press (used only with CALC_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sw  in  4  switch bus carrying A, then B, then the op code in sw[2:0].
- btn_enter  in  1  asynchronous Enter button, active-high.
- btn_clear  in  1  asynchronous Clear button, active-high.
- a_out  out  4  operand A to the calculator.
- b_out  out  4  operand B to the calculator.
- s_out  out  3  op code to the calculator.
- op_valid  out  1  a_out/b_out/s_out form a complete request.
- op_ready  in  1  calculator accepts the request.
- op_err  out  1  one-cycle pulse when an illegal op code is entered.
- state_o  out  2  current FSM state, for LEDs.
- issue_cnt  out  8  number of accepted transactions, wraps.

Behaviour:
- Reset: when rst_n is low at a clk edge, all registers clear; all outputs read 0, state IDLE.
- Button conditioning:
  - Each button passes through a 2-FF synchronizer, then a previous-value register.
  - press = sync & ~prev.
  - A btn_enter first sampled high at edge k gives a press, and the resulting register update, at edge k+2.
  - sw is sampled at that same edge k+2.
- Clear:
  - Uses the synchronized level.
  - Highest priority: while it is high, state goes to IDLE and a/b/s, op_valid and op_err go to 0. issue_cnt is kept.
  - Clear and Enter in the same cycle: Clear wins and the press is dropped.
- FSM (state_o encoding in parentheses):
  - IDLE (0): on press, a_reg <= sw, go to GOT_A.
  - GOT_A (1): on press, b_reg <= sw, go to GOT_B.
  - GOT_B (2): on press:
    - Legal code (sw[3]==0 and sw[2:0]<=OP_MAX): s_reg <= sw[2:0], go to ISSUE, op_valid <= 1.
    - Otherwise: op_err pulses high for exactly 1 cycle and the state stays GOT_B.
  - ISSUE (3):
    - op_valid is held high until op_ready is sampled high.
    - On that edge: go to IDLE, op_valid low from the next cycle, issue_cnt += 1 (modulo 256; 255 wraps to 0).
    - Enter presses in ISSUE are ignored; they are not queued.
- Output stability: a_out/b_out/s_out are driven straight from registers and change only on a capture or on Clear. They stay stable for the whole time op_valid is high.
- op_ready is ignored outside ISSUE.
- Reset while op_valid is high aborts the transaction without counting it.

Optional Feature:
- Macro CALC_DEBOUNCE_EN.
- Defined: a press also requires the synchronized level to have been stable high for DB_CYCLES consecutive cycles. Any low sample restarts the count. One press is generated per held assertion. Latency becomes 2+DB_CYCLES edges.
- Undefined: the raw synchronized edge is used, with 2-edge latency.

Decomposition:
- Package calc_pkg holds:
  - The FSM state typedef: IDLE=0, GOT_A=1, GOT_B=2, ISSUE=3.
  - Op code constants: OP_ADD=0, OP_SUB=1, OP_SADD=2, OP_SSUB=3, OP_CMP=4, OP_SCMP=5.
  - OP_MAX.
- Sub-module calc_btn_cond contains the synchronizer, the edge detect and the optional debounce. It outputs level and press, and is instantiated twice (Enter, Clear).

Test Plan:
- Reset then sequence: sw=3/Enter, sw=9/Enter, sw=1/Enter, with op_ready=0 -> state_o=3, op_valid=1, a_out=3, b_out=9, s_out=1, held for 20 cycles. Then op_ready=1 for 1 cycle -> IDLE, op_valid=0, issue_cnt=1.
- In GOT_B, sw=4'b0110 (6) then Enter -> op_err high for exactly 1 cycle, state stays 2. Then sw=5/Enter -> ISSUE with s_out=5.
- In ISSUE, pulse Enter 3 times with op_ready=0 -> outputs unchanged, state stays 3.
- Clear and Enter asserted together in GOT_A -> IDLE, a_out=0, press not consumed.
- Run 256 transactions -> issue_cnt returns to 0. rst_n low mid-ISSUE -> all outputs 0 on the next edge and the transaction is not counted.
- With CALC_DEBOUNCE_EN and DB_CYCLES=4: a 3-cycle Enter glitch -> no capture. Held high for 10 cycles -> exactly one capture, at edge k+6.
